// File: rtl/nibble_alu_sched.sv
// Round-robin scheduler for the shared nibble-serial 32-bit ALU loop.
// Two requesters are arbitrated, the winning operation is latched and handed
// to the loop, and the result is returned tagged with the requester id over a
// valid/ready response channel.
// Optional build macro: NIBBLE_SCHED_WDT_EN adds a RUN-state watchdog that
// aborts with rsp_err=1 when the loop never reports its final nibble.

package nibble_alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_LSHFT = 3'd5,
    ALU_RSHFT = 3'd6,
    ALU_PASS  = 3'd7
  } alu_cmd_t;
endpackage

// state   | meaning
// IDLE    | arbitrate, accept one request
// START   | pulse loop_start / loop_carry_clr
// RUN     | wait for the loop's final nibble
// CAPTURE | copy loop_result into the response register
// RESP    | hold response until the consumer takes it
module nibble_alu_sched
  import nibble_alu_pkg::*;
#(
  parameter int NIBBLES    = 8,
  parameter int WDT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  alu_cmd_t    req0_cmd,
  input  alu_cmd_t    req1_cmd,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_b,
  output logic        loop_start,
  output logic        loop_reverse,
  output alu_cmd_t    loop_cmd,
  output logic [31:0] loop_word1,
  output logic [31:0] loop_word2,
  output logic        loop_carry_clr,
  input  logic        loop_is_latest,
  input  logic [31:0] loop_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        ptr_q;
  logic        grant;
  logic        accept;
  logic        wdt_abort;
  logic        wdt_expired;
  alu_cmd_t    cmd_q;
  logic [31:0] a_q, b_q;
  logic        id_q;
  logic [31:0] data_q;

`ifdef NIBBLE_SCHED_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  logic [WDT_W-1:0] wdt_cnt_q;
  logic             err_q;
  // NIBBLES only sets the nominal latency; the loop itself defines it.
  logic [31:0]      unused_params;
  assign unused_params = 32'(NIBBLES);

  assign wdt_expired = (wdt_cnt_q == '0);

  // Down-counter loaded on the way into RUN; terminal count means timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt_q <= '0;
    end else if (state_q == S_START) begin
      wdt_cnt_q <= WDT_W'(WDT_CYCLES - 1);
    end else if (state_q == S_RUN && !wdt_expired) begin
      wdt_cnt_q <= wdt_cnt_q - WDT_W'(1);
    end
  end

  // Error flag travels with the response word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_q == S_CAPTURE) begin
      err_q <= 1'b0;
    end else if (wdt_abort) begin
      err_q <= 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  // Without the watchdog both parameters are informational only.
  logic [63:0] unused_params;
  assign unused_params = {32'(NIBBLES), 32'(WDT_CYCLES)};
  assign wdt_expired   = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, arbitration and loop control strobes.
  always_comb begin
    state_d        = state_q;
    req_ready      = 2'b00;
    accept         = 1'b0;
    wdt_abort      = 1'b0;
    loop_start     = 1'b0;
    loop_carry_clr = 1'b0;
    grant          = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = grant ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        loop_start     = 1'b1;
        loop_carry_clr = 1'b1;
        state_d        = S_RUN;
      end
      S_RUN: begin
        if (loop_is_latest) begin
          state_d = S_CAPTURE;
        end else if (wdt_expired) begin
          wdt_abort = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_CAPTURE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operation latch and round-robin pointer, updated only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
      id_q  <= 1'b0;
      cmd_q <= ALU_ADD;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      ptr_q <= ~grant;
      id_q  <= grant;
      cmd_q <= grant ? req1_cmd : req0_cmd;
      a_q   <= grant ? req1_a : req0_a;
      b_q   <= grant ? req1_b : req0_b;
    end
  end

  // Response word: loop result on capture, zero on watchdog abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (state_q == S_CAPTURE) begin
      data_q <= loop_result;
    end else if (wdt_abort) begin
      data_q <= '0;
    end
  end

  assign loop_cmd     = cmd_q;
  assign loop_word1   = a_q;
  assign loop_word2   = b_q;
  assign loop_reverse = (cmd_q == ALU_RSHFT);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_id       = id_q;
  assign rsp_data     = data_q;
  assign busy         = (state_q != S_IDLE);

endmodule
